// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types and constants for the two-master register arbiter
package reg_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} arb_state_e;
  typedef logic req_id_t;
  localparam int REQ_NUM = 2;
endpackage

// File: rtl/reg_arb_rr2.sv
// reg_arb_rr2: two-way round-robin grant selection
module reg_arb_rr2
  import reg_arb_pkg::*;
(
  input  logic [REQ_NUM-1:0] req,
  input  req_id_t            rr_ptr,
  output req_id_t            gnt_id,
  output logic               gnt_vld
);
  always_comb begin
    gnt_vld = |req;
    gnt_id  = &req ? rr_ptr : req_id_t'(req[1]);
  end
endmodule

// File: rtl/reg_native_arb2.sv
// reg_native_arb2: round-robin arbiter of two reg_native requesters onto one slave, with timeout
module reg_native_arb2
  import reg_arb_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 64,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(32'hDEAD_BEEF)
)(
  input  logic                  fsm_clk,
  input  logic                  fsm_rstn,
  input  logic                  soft_rst,
  input  logic                  m0_req_vld,
  input  logic                  m0_wr_en,
  input  logic                  m0_rd_en,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wr_data,
  output logic                  m0_ack_vld,
  output logic [DATA_WIDTH-1:0] m0_rd_data,
  output logic                  m0_err,
  input  logic                  m1_req_vld,
  input  logic                  m1_wr_en,
  input  logic                  m1_rd_en,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wr_data,
  output logic                  m1_ack_vld,
  output logic [DATA_WIDTH-1:0] m1_rd_data,
  output logic                  m1_err,
  output logic                  req_vld,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  ack_vld,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  timeout_o,
  output logic                  busy
);
  localparam int             CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_e            state, state_nxt;
  req_id_t               rr_ptr, gnt, gid;
  logic                  gv, done;
  logic [CW-1:0]         cnt;
  logic [REQ_NUM-1:0]    m_req, m_wr, m_rd, m_ack, m_err;
  logic [ADDR_WIDTH-1:0] m_addr  [REQ_NUM];
  logic [DATA_WIDTH-1:0] m_wdata [REQ_NUM];
  logic [DATA_WIDTH-1:0] m_rdata [REQ_NUM];

  assign m_req      = {m1_req_vld, m0_req_vld};
  assign m_wr       = {m1_wr_en, m0_wr_en};
  assign m_rd       = {m1_rd_en, m0_rd_en};
  assign m_addr     = '{m0_addr, m1_addr};
  assign m_wdata    = '{m0_wr_data, m1_wr_data};
  assign m0_ack_vld = m_ack[0];
  assign m1_ack_vld = m_ack[1];
  assign m0_err     = m_err[0];
  assign m1_err     = m_err[1];
  assign m0_rd_data = m_rdata[0];
  assign m1_rd_data = m_rdata[1];

  reg_arb_rr2 u_rr (
    .req     (m_req),
    .rr_ptr  (rr_ptr),
    .gnt_id  (gid),
    .gnt_vld (gv)
  );

  // an ack in the last WAIT cycle still completes the access without error
  assign done = state == WAIT && (ack_vld || cnt == CNT_LAST);

  always_comb begin
    state_nxt = soft_rst         ? IDLE
              : state == IDLE    ? (gv ? WAIT : IDLE)
              : state == WAIT    ? (done ? RESP : WAIT)
              : IDLE;
  end

  always_ff @(posedge fsm_clk or negedge fsm_rstn) begin
    if (!fsm_rstn) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge fsm_clk or negedge fsm_rstn) begin
    if (!fsm_rstn) begin
      rr_ptr    <= '0;
      gnt       <= '0;
      cnt       <= '0;
      req_vld   <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      addr      <= '0;
      wr_data   <= '0;
      timeout_o <= 1'b0;
      busy      <= 1'b0;
      m_ack     <= '0;
      m_err     <= '0;
      m_rdata   <= '{default: '0};
    end else begin
      m_ack     <= '0;
      timeout_o <= 1'b0;
      busy      <= state_nxt != IDLE;
      if (soft_rst) begin
        req_vld <= 1'b0;
        wr_en   <= 1'b0;
        rd_en   <= 1'b0;
        rr_ptr  <= '0;
        cnt     <= '0;
      end else if (state == IDLE && gv) begin
        gnt     <= gid;
        rr_ptr  <= ~gid;
        cnt     <= '0;
        req_vld <= 1'b1;
        wr_en   <= m_wr[gid];
        rd_en   <= m_rd[gid];
        addr    <= m_addr[gid];
        wr_data <= m_wdata[gid];
      end else if (done) begin
        req_vld      <= 1'b0;
        m_ack[gnt]   <= 1'b1;
        m_rdata[gnt] <= ack_vld ? rd_data : ERR_DATA;
        m_err[gnt]   <= !ack_vld;
        timeout_o    <= !ack_vld;
      end else if (state == WAIT) begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_reg_native_arb2.sv
// tb_reg_native_arb2: randomized transaction-level check of reg_native_arb2 against a reference model
module tb_reg_native_arb2;
  localparam int          TMO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        fsm_clk = 0, fsm_rstn = 0, soft_rst = 0;
  logic [1:0]  mreq = '0;
  logic        pl_wr [2], pl_rd [2];
  logic [63:0] pl_addr [2];
  logic [31:0] pl_wd [2];
  logic        m0_ack_vld, m0_err, m1_ack_vld, m1_err;
  logic [31:0] m0_rd_data, m1_rd_data;
  logic        req_vld, wr_en, rd_en, timeout_o, busy;
  logic [63:0] addr;
  logic [31:0] wr_data;
  logic        ack_vld = 0;
  logic [31:0] rd_data = '0;

  int          n_chk = 0, n_fail = 0;
  int          ptr = 0;
  logic [31:0] last_rd [2] = '{0, 0};
  logic        last_err [2] = '{0, 0};

  always #5 fsm_clk = ~fsm_clk;

  reg_native_arb2 #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO), .ERR_DATA(ERR)) dut (
    .fsm_clk(fsm_clk), .fsm_rstn(fsm_rstn), .soft_rst(soft_rst),
    .m0_req_vld(mreq[0]), .m0_wr_en(pl_wr[0]), .m0_rd_en(pl_rd[0]), .m0_addr(pl_addr[0]),
    .m0_wr_data(pl_wd[0]), .m0_ack_vld(m0_ack_vld), .m0_rd_data(m0_rd_data), .m0_err(m0_err),
    .m1_req_vld(mreq[1]), .m1_wr_en(pl_wr[1]), .m1_rd_en(pl_rd[1]), .m1_addr(pl_addr[1]),
    .m1_wr_data(pl_wd[1]), .m1_ack_vld(m1_ack_vld), .m1_rd_data(m1_rd_data), .m1_err(m1_err),
    .req_vld(req_vld), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
    .ack_vld(ack_vld), .rd_data(rd_data), .timeout_o(timeout_o), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge fsm_clk);
    #1;
  endtask

  task automatic set_pl(input int id, input logic [63:0] a, input logic [31:0] d, input logic w, input logic r);
    pl_addr[id] = a;
    pl_wd[id]   = d;
    pl_wr[id]   = w;
    pl_rd[id]   = r;
  endtask

  task automatic rand_pl(input int id);
    set_pl(id, {$urandom, $urandom}, $urandom, 1'($urandom), 1'($urandom));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_vld"}, 64'(req_vld), 0);
    check({tag, "_acks"}, 64'({m1_ack_vld, m0_ack_vld}), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_timeout"}, 64'(timeout_o), 0);
  endtask

  // Called in the cycle the arbiter is idle and sees requester id selected; the slave
  // answers d cycles into the wait (never if d >= TMO), then the upstream ack is checked.
  task automatic serve(input int id, input int d, input logic [31:0] sd);
    int          o = 1 - id;
    logic        exp_err = d >= TMO;
    logic [31:0] exp_rd = exp_err ? ERR : sd;
    tick();
    check("dn_addr", addr, pl_addr[id]);
    check("dn_wr_data", 64'(wr_data), 64'(pl_wd[id]));
    check("dn_wr_rd", 64'({wr_en, rd_en}), 64'({pl_wr[id], pl_rd[id]}));
    check("dn_busy", 64'(busy), 1);
    for (int k = 0; k < TMO; k++) begin
      check("wait_req_vld", 64'(req_vld), 1);
      check("wait_up_ack", 64'({m1_ack_vld, m0_ack_vld, timeout_o}), 0);
      if (k == d) begin
        ack_vld = 1;
        rd_data = sd;
      end
      tick();
      ack_vld = 0;
      rd_data = $urandom;
      if (k == d) break;
    end
    check("up_ack", 64'({m1_ack_vld, m0_ack_vld}), 64'(2'b01 << id));
    check("up_rd_data", 64'(id ? m1_rd_data : m0_rd_data), 64'(exp_rd));
    check("up_err", 64'(id ? m1_err : m0_err), 64'(exp_err));
    check("timeout_o", 64'(timeout_o), 64'(exp_err));
    check("resp_req_vld", 64'(req_vld), 0);
    check("other_hold", 64'({o ? m1_rd_data : m0_rd_data, o ? m1_err : m0_err}), 64'({last_rd[o], last_err[o]}));
    last_rd[id]  = exp_rd;
    last_err[id] = exp_err;
    ptr          = o;
    mreq[id]     = 0;
    tick();
    check("post_busy", 64'(busy), 0);
    check("post_acks", 64'({m1_ack_vld, m0_ack_vld}), 0);
  endtask

  // Both pending: pointer decides; single pending: that one.
  task automatic round(input logic [1:0] sel);
    for (int i = 0; i < 2; i++) if (sel[i]) rand_pl(i);
    mreq = sel;
    while (mreq != 0)
      serve(mreq == 2'b11 ? ptr : (mreq[1] ? 1 : 0), $urandom_range(0, TMO + 1), $urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rand_pl(0);
    rand_pl(1);
    tick();
    tick();
    check_idle_outputs("in_reset");
    check("in_reset_addr", addr, 0);
    fsm_rstn = 1;
    tick();
    check_idle_outputs("after_reset");
    check("after_reset_rd", 64'({m1_rd_data, m0_rd_data}), 0);
    round(2'b11);
    for (int r = 0; r < 4; r++) round(2'b11);
    set_pl(0, 64'h10, 32'h0, 1, 0);
    mreq = 2'b01;
    serve(0, 1, $urandom);
    set_pl(1, 64'h44, 32'h0, 0, 1);
    mreq = 2'b10;
    serve(1, 0, 32'hFFFF_FFFF);
    set_pl(0, 64'h80, 32'h1234_5678, 1, 0);
    mreq = 2'b01;
    serve(0, TMO, $urandom);
    tick();
    ack_vld = 1;
    tick();
    ack_vld = 0;
    check_idle_outputs("late_ack");
    tick();
    check_idle_outputs("late_ack2");
    check("late_ack_rd", 64'({m0_rd_data, m0_err}), 64'({ERR, 1'b1}));
    rand_pl(0);
    mreq = 2'b01;
    tick();
    check("sr_wait_req", 64'(req_vld), 1);
    soft_rst = 1;
    mreq = 0;
    tick();
    soft_rst = 0;
    check_idle_outputs("soft_rst");
    check("soft_rst_wr_rd", 64'({wr_en, rd_en}), 0);
    tick();
    check_idle_outputs("soft_rst2");
    ptr = 0;
    round(2'b11);
    rand_pl(1);
    mreq = 2'b10;
    tick();
    check("ar_wait_req", 64'(req_vld), 1);
    #2 fsm_rstn = 0;
    #1;
    check_idle_outputs("async_rst");
    check("async_rst_pl", 64'({wr_en, rd_en, m1_err, m0_err}), 0);
    check("async_rst_rd", 64'({m1_rd_data, m0_rd_data}), 0);
    mreq = 0;
    tick();
    tick();
    fsm_rstn = 1;
    ptr = 0;
    last_rd  = '{0, 0};
    last_err = '{0, 0};
    tick();
    round(2'b11);
    for (int r = 0; r < 40; r++) round(2'($urandom_range(1, 3)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
